cc_muxn_scan: RTL and testbench

CC_MUXN_SCAN -- requirements
Module: CC_MUXN_SCAN

---
 rtl/cc_muxn_scan_pkg.sv | 28 ++
 rtl/cc_muxn_scan_nextch.sv | 41 ++++
 rtl/cc_muxn_scan.sv | 143 ++++++++++++++
 tb/tb_cc_muxn_scan.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_muxn_scan_pkg.sv
// -----------------------------------------------------------------------------
// cc_muxn_scan_pkg
// Shared definitions for the scanning N-way multiplexer:
//   - default parameter values for cc_muxn_scan
//   - mode input encoding (direct / scan)
//   - FSM state encoding (DIRECT = 0, SCAN = 1)
//   - dwell counter width
// -----------------------------------------------------------------------------
package cc_muxn_scan_pkg;

    localparam int MUXN_CHANNELS_DEF    = 4;
    localparam int MUXN_DATAWIDTH_DEF   = 8;
    localparam int MUXN_SELECTWIDTH_DEF = 2;
    localparam int MUXN_DWELL_DEF       = 4;

    // Dwell counter is a fixed 8 bits, enough for any dwell of 1..255.
    localparam int DWELL_CNT_W = 8;

    // Encoding of the mode input.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

endpackage

// File: rtl/cc_muxn_scan_nextch.sv
// -----------------------------------------------------------------------------
// cc_muxn_nextch
// Purely combinational next-enabled-channel search. Starting at cur_i+1 and
// rotating through all channels (wrapping from MUXN_CHANNELS-1 to 0, and
// finally back to cur_i itself), returns the first channel whose mask bit is
// set.
//
// Ports:
//   cur_i   : current channel index (must be < MUXN_CHANNELS)
//   mask_i  : per-channel enable mask
//   next_o  : next enabled channel (cur_i when nothing is enabled)
//   found_o : at least one channel is enabled
// -----------------------------------------------------------------------------
module cc_muxn_nextch
    import cc_muxn_scan_pkg::*;
#(
    parameter int MUXN_CHANNELS    = MUXN_CHANNELS_DEF,
    parameter int MUXN_SELECTWIDTH = MUXN_SELECTWIDTH_DEF
) (
    input  logic [MUXN_SELECTWIDTH-1:0] cur_i,
    input  logic [MUXN_CHANNELS-1:0]    mask_i,
    output logic [MUXN_SELECTWIDTH-1:0] next_o,
    output logic                        found_o
);

    // Mask rotated so that bit j corresponds to channel (cur_i + 1 + j) mod N.
    logic [2*MUXN_CHANNELS-1:0] mask_dbl;

    always_comb begin
        mask_dbl = {mask_i, mask_i} >> (int'(cur_i) + 1);
        next_o   = cur_i;
        found_o  = |mask_i;
        // Walk from the far end down so the nearest enabled channel wins.
        for (int j = MUXN_CHANNELS - 1; j >= 0; j--) begin
            if (mask_dbl[j]) begin
                next_o = MUXN_SELECTWIDTH'((int'(cur_i) + 1 + j) % MUXN_CHANNELS);
            end
        end
    end

endmodule

// File: rtl/cc_muxn_scan.sv
// -----------------------------------------------------------------------------
// cc_muxn_scan
// Registered N-way multiplexer with two modes:
//   DIRECT : output the channel chosen by select_InBUS (1-cycle latency).
//   SCAN   : rotate over the channels enabled in mask_InBUS, dwelling
//            MUXN_DWELL cycles on each, re-sampling live data every cycle.
//
// Ports:
//   CC_MUXN_SCAN_CLOCK_50       : clock, rising edge
//   CC_MUXN_SCAN_RESET_InHigh   : asynchronous active-high reset
//   CC_MUXN_SCAN_data_InBUS     : flattened channels, channel i at [i*W +: W]
//   CC_MUXN_SCAN_select_InBUS   : channel index used in direct mode
//   CC_MUXN_SCAN_mode_In        : 0 = direct, 1 = scan
//   CC_MUXN_SCAN_mask_InBUS     : per-channel scan enable
//   CC_MUXN_SCAN_z_OutBUS       : registered selected data
//   CC_MUXN_SCAN_channel_OutBUS : channel index z_OutBUS was sampled from
//   CC_MUXN_SCAN_valid_Out      : z_OutBUS holds data from a legal, enabled channel
// -----------------------------------------------------------------------------
module cc_muxn_scan
    import cc_muxn_scan_pkg::*;
#(
    parameter int MUXN_CHANNELS    = MUXN_CHANNELS_DEF,
    parameter int MUXN_DATAWIDTH   = MUXN_DATAWIDTH_DEF,
    parameter int MUXN_SELECTWIDTH = MUXN_SELECTWIDTH_DEF,
    parameter int MUXN_DWELL       = MUXN_DWELL_DEF
) (
    input  logic                                    CC_MUXN_SCAN_CLOCK_50,
    input  logic                                    CC_MUXN_SCAN_RESET_InHigh,
    input  logic [MUXN_CHANNELS*MUXN_DATAWIDTH-1:0] CC_MUXN_SCAN_data_InBUS,
    input  logic [MUXN_SELECTWIDTH-1:0]             CC_MUXN_SCAN_select_InBUS,
    input  logic                                    CC_MUXN_SCAN_mode_In,
    input  logic [MUXN_CHANNELS-1:0]                CC_MUXN_SCAN_mask_InBUS,
    output logic [MUXN_DATAWIDTH-1:0]               CC_MUXN_SCAN_z_OutBUS,
    output logic [MUXN_SELECTWIDTH-1:0]             CC_MUXN_SCAN_channel_OutBUS,
    output logic                                    CC_MUXN_SCAN_valid_Out
);

    state_e                      state_q, state_d;
    logic [MUXN_DATAWIDTH-1:0]   z_q, z_d;
    logic [MUXN_SELECTWIDTH-1:0] ch_q, ch_d;
    logic                        valid_q, valid_d;
    logic [DWELL_CNT_W-1:0]      dwell_q, dwell_d;

    logic                        hold_z;
    logic                        sel_legal;
    logic                        cur_en;
    logic                        any_en;
    logic [MUXN_SELECTWIDTH-1:0] search_from;
    logic [MUXN_SELECTWIDTH-1:0] next_ch;
    logic [MUXN_DATAWIDTH-1:0]   ch_data;

    // On scan entry the search starts from the last channel so that the
    // rotation lands on the lowest enabled index.
    assign search_from = (state_q == ST_SCAN) ? ch_q
                                              : MUXN_SELECTWIDTH'(MUXN_CHANNELS - 1);

    cc_muxn_nextch #(
        .MUXN_CHANNELS    (MUXN_CHANNELS),
        .MUXN_SELECTWIDTH (MUXN_SELECTWIDTH)
    ) u_nextch (
        .cur_i   (search_from),
        .mask_i  (CC_MUXN_SCAN_mask_InBUS),
        .next_o  (next_ch),
        .found_o (any_en)
    );

    assign sel_legal = 32'(CC_MUXN_SCAN_select_InBUS) < 32'(MUXN_CHANNELS);
    assign cur_en    = |(CC_MUXN_SCAN_mask_InBUS & (MUXN_CHANNELS'(1) << ch_q));

    // Next-state decision for mode, channel, validity and dwell count.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        dwell_d = dwell_q;
        hold_z  = 1'b0;

        if (CC_MUXN_SCAN_mode_In == MODE_DIRECT) begin
            state_d = ST_DIRECT;
            dwell_d = '0;
            if (sel_legal) begin
                ch_d    = CC_MUXN_SCAN_select_InBUS;
                valid_d = 1'b1;
            end else begin
                ch_d    = '0;
                valid_d = 1'b0;
            end
        end else begin
            state_d = ST_SCAN;
            if (!any_en) begin
                // Nothing enabled: freeze the outputs and mark them stale.
                hold_z  = 1'b1;
                valid_d = 1'b0;
                dwell_d = '0;
            end else if (state_q == ST_DIRECT || !cur_en
                         || dwell_q == DWELL_CNT_W'(MUXN_DWELL - 1)) begin
                // Entry, current channel disabled, or dwell complete: move on.
                ch_d    = next_ch;
                valid_d = 1'b1;
                dwell_d = '0;
            end else begin
                valid_d = 1'b1;
                dwell_d = dwell_q + DWELL_CNT_W'(1);
            end
        end
    end

    // Data is always taken from the channel being loaded, keeping z and
    // channel paired on the same edge.
    always_comb begin
        ch_data = '0;
        for (int i = 0; i < MUXN_CHANNELS; i++) begin
            if (ch_d == MUXN_SELECTWIDTH'(i)) begin
                ch_data = CC_MUXN_SCAN_data_InBUS[i*MUXN_DATAWIDTH +: MUXN_DATAWIDTH];
            end
        end
        z_d = hold_z ? z_q : ch_data;
    end

    always_ff @(posedge CC_MUXN_SCAN_CLOCK_50 or posedge CC_MUXN_SCAN_RESET_InHigh) begin
        if (CC_MUXN_SCAN_RESET_InHigh) begin
            state_q <= ST_DIRECT;
            z_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            dwell_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            z_q     <= z_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            dwell_q <= dwell_d;
        end
    end

    assign CC_MUXN_SCAN_z_OutBUS       = z_q;
    assign CC_MUXN_SCAN_channel_OutBUS = ch_q;
    assign CC_MUXN_SCAN_valid_Out      = valid_q;

endmodule

// File: tb/tb_cc_muxn_scan.sv
// -----------------------------------------------------------------------------
// tb_cc_muxn_scan
// Two instances share one stimulus: dut_a with 4 channels and dut_b with 3
// channels (so select=3 is out of range for it). A reference model built from
// the mux/scan rules predicts each edge's outputs into a queue per instance; a
// monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_cc_muxn_scan;

    localparam int W     = 8;
    localparam int SW    = 2;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [1:0]  sel;
    logic        mode;
    logic [3:0]  mask;

    logic [7:0]  z_a, z_b;
    logic [1:0]  ch_a, ch_b;
    logic        v_a, v_b;

    always #5 clk = ~clk;

    cc_muxn_scan #(
        .MUXN_CHANNELS(4), .MUXN_DATAWIDTH(W), .MUXN_SELECTWIDTH(SW), .MUXN_DWELL(DWELL)
    ) dut_a (
        .CC_MUXN_SCAN_CLOCK_50       (clk),
        .CC_MUXN_SCAN_RESET_InHigh   (rst),
        .CC_MUXN_SCAN_data_InBUS     (data),
        .CC_MUXN_SCAN_select_InBUS   (sel),
        .CC_MUXN_SCAN_mode_In        (mode),
        .CC_MUXN_SCAN_mask_InBUS     (mask),
        .CC_MUXN_SCAN_z_OutBUS       (z_a),
        .CC_MUXN_SCAN_channel_OutBUS (ch_a),
        .CC_MUXN_SCAN_valid_Out      (v_a)
    );

    cc_muxn_scan #(
        .MUXN_CHANNELS(3), .MUXN_DATAWIDTH(W), .MUXN_SELECTWIDTH(SW), .MUXN_DWELL(DWELL)
    ) dut_b (
        .CC_MUXN_SCAN_CLOCK_50       (clk),
        .CC_MUXN_SCAN_RESET_InHigh   (rst),
        .CC_MUXN_SCAN_data_InBUS     (data[23:0]),
        .CC_MUXN_SCAN_select_InBUS   (sel),
        .CC_MUXN_SCAN_mode_In        (mode),
        .CC_MUXN_SCAN_mask_InBUS     (mask[2:0]),
        .CC_MUXN_SCAN_z_OutBUS       (z_b),
        .CC_MUXN_SCAN_channel_OutBUS (ch_b),
        .CC_MUXN_SCAN_valid_Out      (v_b)
    );

    typedef struct {
        bit       scan;
        int       ch;
        int       dwell;
        bit [7:0] z;
        bit       valid;
    } model_t;

    typedef struct {
        bit [7:0] z;
        int       ch;
        bit       valid;
    } exp_t;

    model_t ma, mb;
    exp_t   qa[$], qb[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.scan  = 1'b0;
        m.ch    = 0;
        m.dwell = 0;
        m.z     = 8'h00;
        m.valid = 1'b0;
        return m;
    endfunction

    function automatic bit [7:0] byte_of(input logic [31:0] d, input int idx);
        return 8'(d >> (8 * idx));
    endfunction

    function automatic bit mask_bit(input logic [3:0] mk, input int idx);
        return ((mk >> idx) & 4'd1) != 4'd0;
    endfunction

    // One clock edge of the reference behaviour for an n-channel mux.
    function automatic model_t mstep(input model_t m, input int n, input bit md,
                                     input int s, input logic [3:0] mk,
                                     input logic [31:0] d);
        int en[$];
        int nxt;
        for (int i = 0; i < n; i++) if (mask_bit(mk, i)) en.push_back(i);
        if (!md) begin
            m.scan  = 1'b0;
            m.dwell = 0;
            m.valid = (s < n);
            m.ch    = (s < n) ? s : 0;
            m.z     = byte_of(d, m.ch);
        end else if (en.size() == 0) begin
            m.scan  = 1'b1;
            m.dwell = 0;
            m.valid = 1'b0;
        end else begin
            if (m.scan && mask_bit(mk, m.ch) && m.dwell < DWELL - 1) begin
                m.dwell++;
            end else begin
                // Lowest enabled on entry; otherwise first enabled above the
                // current channel, wrapping round to the lowest.
                nxt = en[0];
                if (m.scan) begin
                    for (int k = en.size() - 1; k >= 0; k--) if (en[k] > m.ch) nxt = en[k];
                end
                m.ch    = nxt;
                m.dwell = 0;
            end
            m.scan  = 1'b1;
            m.valid = 1'b1;
            m.z     = byte_of(d, m.ch);
        end
        return m;
    endfunction

    // Advance one edge: predict both instances from the inputs sampled at the
    // edge, then move off the edge before the caller changes inputs.
    task automatic step();
        exp_t e;
        @(posedge clk);
        ma = mstep(ma, 4, mode, int'(sel), mask, data);
        mb = mstep(mb, 3, mode, int'(sel), mask, data);
        e.z = ma.z; e.ch = ma.ch; e.valid = ma.valid; qa.push_back(e);
        e.z = mb.z; e.ch = mb.ch; e.valid = mb.valid; qb.push_back(e);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_z_a"},  int'(z_a),  0);
        check({tag, "_ch_a"}, int'(ch_a), 0);
        check({tag, "_v_a"},  int'(v_a),  0);
        check({tag, "_z_b"},  int'(z_b),  0);
        check({tag, "_ch_b"}, int'(ch_b), 0);
        check({tag, "_v_b"},  int'(v_b),  0);
    endtask

    // Monitor: compare whatever the model predicted for the last edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("z_a",  int'(z_a),  int'(e.z));
                check("ch_a", int'(ch_a), e.ch);
                check("v_a",  int'(v_a),  int'(e.valid));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("z_b",  int'(z_b),  int'(e.z));
                check("ch_b", int'(ch_b), e.ch);
                check("v_b",  int'(v_b),  int'(e.valid));
            end
        end
    end

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        sel  = 2'd0;
        mask = 4'h0;
        data = 32'h0;
        ma   = model_reset();
        mb   = model_reset();
        #2;
        check_zero("reset");
        @(negedge clk);
        #2 rst = 1'b0;

        // Direct mode, select stepped 0..3 on fixed data.
        data = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
        end

        // Scan over all four channels with live data, long enough to wrap.
        mode = 1'b1;
        mask = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            data = $urandom;
            step();
        end

        // Scan over channels 1 and 3, then remove every enable mid-dwell.
        mode = 1'b0;
        step();
        mode = 1'b1;
        mask = 4'b1010;
        for (int i = 0; i < 14; i++) begin
            data = $urandom;
            step();
        end
        mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            data = $urandom;
            step();
        end

        // Re-enter scan; drop channel 2 when it is at dwell count 1.
        mode = 1'b0;
        step();
        mode = 1'b1;
        mask = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            data = $urandom;
            step();
        end
        mask = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            data = $urandom;
            step();
        end

        // Reset pulse between edges in the middle of a scan.
        mask = 4'b1100;
        for (int i = 0; i < 6; i++) begin
            data = $urandom;
            step();
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_zero("async_reset");
        ma = model_reset();
        mb = model_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data = $urandom;
            step();
        end

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            data = $urandom;
            sel  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 12) mode = ~mode;
            if ($urandom_range(0, 99) < 20) mask = 4'($urandom_range(0, 15));
            step();
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", qa.size() + qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
